multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore-style FSM that sequences a multicycle MIPS datapath (PC, IR, register file, ALU, unified memory) through fetch/decode/execute/memory/writeback for each instruction.
- Decodes the 6-bit opcode from IR and drives per-state datapath enables and mux selects.
- Handles a variable-latency memory via a ready handshake with a bounded wait.
- Sits between the instruction register and the datapath muxes; ALU function decode stays in the existing ALU control logic, driven by `alu_op`.

Parameters:
- WAIT_LIMIT, 15, maximum cycles spent in any memory-wait state before abort; range 1..255.
- CNT_W, $clog2(WAIT_LIMIT+1), width of the wait counter; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- i_or_d  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  regfile write data: 0=ALUOut, 1=MDR
- reg_dst  out  1  write register: 0=rt, 1=rd
- reg_write  out  1  regfile write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct decode
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- mem_err  out  1  one-cycle pulse on memory wait timeout
- state  out  4  current state encoding, for debug

Behaviour:
- Reset (sync, active-high):
  - Every output is 0 in any cycle where reset=1.
  - The first cycle after reset deasserts is in state FETCH.
- Outputs are decoded from state only, except `ir_write`, `pc_write` in FETCH and `instr_done` in MEMWR, which are qualified by `mem_ready`. Any signal not listed for a state is 0.
- State encodings, per-state outputs and transitions:
  - FETCH=0: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Goes to DECODE on mem_ready, otherwise waits.
  - DECODE=1: alu_src_a=0, alu_src_b=11, alu_op=00. Dispatch on opcode:
    - 0x00 -> EXEC
    - 0x23 or 0x2B -> MEMADR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> ADDIEX (only when the optional feature is compiled in)
    - anything else -> ILLEGAL
  - MEMADR=2: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEMRD if opcode=0x23, else MEMWR.
  - MEMRD=3: mem_read=1, i_or_d=1. Goes to MEMWB on mem_ready.
  - MEMWB=4: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Goes to FETCH.
  - MEMWR=5: mem_write=1, i_or_d=1; instr_done=mem_ready. Goes to FETCH on mem_ready.
  - EXEC=6: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
  - ALUWB=7: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Goes to FETCH.
  - BRANCH=8: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH.
  - JUMP=9: pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
  - ILLEGAL=12: illegal_op=1. Goes to FETCH; the instruction is skipped because PC already advanced.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle the FSM stays in that state with mem_ready=0.
  - When the counter reaches WAIT_LIMIT with mem_ready still 0: mem_err=1 for that cycle, no write strobes assert, next state is FETCH. A timed-out fetch is retried at the same PC; a timed-out load/store is abandoned without retiring.
  - If mem_ready=1 arrives in the same cycle the limit is reached, the transfer completes normally and mem_err stays 0.
- Latency in cycles, with zero memory wait: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each memory-wait cycle adds 1.
- Reset mid-instruction: the FSM aborts immediately to FETCH with no partial writes.
- Unused encodings 13–15 go to FETCH on the next cycle with all outputs 0.

Optional Feature:
- Macro `MULTICYCLE_ADDI_EN`.
- Defined:
  - Opcode 0x08 dispatches to ADDIEX=10 (alu_src_a=1, alu_src_b=10, alu_op=00), then to ADDIWB=11 (reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1), then to FETCH.
- Undefined:
  - 0x08 takes the ILLEGAL path.
  - Encodings 10 and 11 are treated as unused.

Decomposition:
- Shared package `mips_pkg`:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - state enum typedef `mc_state_t` (4-bit)
  - alu_op, alu_src_b and pc_source encodings
- One sub-module: `mem_wait_timer`, holding the counter, its clear/increment logic and the timeout compare against WAIT_LIMIT.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 → all outputs 0 during reset; state=0 on the first cycle after release; ir_write=pc_write=1 in that cycle.
- R-type (opcode=0x00), mem_ready always 1 → state sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; instr_done pulses once, in cycle 4.
- lw (0x23) with mem_ready held low for 3 cycles in MEMRD → sequence 0,1,2,3,3,3,3,4,0; mem_read=1 and i_or_d=1 throughout state 3; mem_to_reg=1 and reg_write=1 in state 4.
- sw (0x2B) with WAIT_LIMIT=4 and mem_ready never asserted → after 4 cycles in state 5, mem_err pulses, next state 0, instr_done never asserts.
- Opcode 0x3F, then 0x08 with the macro off → illegal_op pulses once in state 12 for each, then FETCH; with the macro on, 0x08 runs 0,1,10,11,0 with reg_write=1 and reg_dst=0 in state 11.
- beq (0x04), then j (0x02) → pc_write_cond=1 and alu_op=01 in state 8; pc_write=1 and pc_source=10 in state 9; each instruction takes 3 cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, FSM states,
// and datapath mux/ALU encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_ILLEGAL = 4'd12
  } mc_state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // States that hold a memory transaction open and may stall on mem_ready.
  function automatic logic is_wait_state(input mc_state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded wait counter for memory states; flags timeout on the cycle the
// WAIT_LIMIT-th stalled cycle would be reached.
module mem_wait_timer
  import mips_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = $clog2(WAIT_LIMIT + 1)
) (
  input  logic      clk,
  input  logic      reset,
  input  mc_state_t state,
  input  logic      mem_ready,
  output logic      timeout
);

  logic             waiting;
  logic [CNT_W-1:0] cnt;

  assign waiting = is_wait_state(state);
  // Counter holds the number of stalled cycles already spent; this cycle is the last allowed one.
  assign timeout = waiting && !mem_ready && (cnt == CNT_W'(WAIT_LIMIT - 1));

  // Any cycle that does not stay stalled in a wait state clears, so entry always starts at zero.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (waiting && !mem_ready && !timeout)
      cnt <= cnt + CNT_W'(1);
    else
      cnt <= '0;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multicycle MIPS datapath. Define MULTICYCLE_ADDI_EN
// to add addi support (states 10/11); otherwise opcode 0x08 is illegal.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

  mc_state_t state_q;
  logic      timeout;

  mem_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .state     (state_q),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:     state_q <= S_EXEC;
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
            OP_ADDI:      state_q <= S_ADDIEX;
`endif
            default:      state_q <= S_ILLEGAL;
          endcase
        end
        S_MEMADR: state_q <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (mem_ready)    state_q <= S_MEMWB;
          else if (timeout) state_q <= S_FETCH;
          else              state_q <= S_MEMRD;
        end
        S_MEMWR:  state_q <= (mem_ready || timeout) ? S_FETCH : S_MEMWR;
        S_EXEC:   state_q <= S_ALUWB;
`ifdef MULTICYCLE_ADDI_EN
        S_ADDIEX: state_q <= S_ADDIWB;
`endif
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  assign state = reset ? 4'd0 : state_q;

  // Gating on reset keeps every strobe low while reset is held, even mid-instruction.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCS_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    mem_err       = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          mem_err   = timeout;
        end
        S_DECODE: alu_src_b = SRCB_IMM_SH;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          mem_err  = timeout;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          // An abandoned store drops its strobe in the timeout cycle.
          mem_write  = !timeout;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
          mem_err    = timeout;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_ALUWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCS_ALUOUT;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCS_JUMP;
          instr_done = 1'b1;
        end
`ifdef MULTICYCLE_ADDI_EN
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
`endif
        S_ILLEGAL: illegal_op = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// trace from the opcode and chosen memory waits, then replayed against the DUT.
module tb_multicycle_controller;

  localparam int WL = 4;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op, mem_err;
  logic [3:0] state;
  logic [22:0] all_outs;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] st;
    logic rdy, done, err, ill, regw;
  } step_t;
  step_t q[$];

  multicycle_controller #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_err(mem_err), .state(state)
  );

  assign all_outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     pc_source, instr_done, illegal_op, mem_err, state};

  always #5 clk = ~clk;

  function automatic logic rr();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic [3:0] st, input logic rdy, done, err, ill, regw);
    step_t s;
    s.st = st; s.rdy = rdy; s.done = done; s.err = err; s.ill = ill; s.regw = regw;
    q.push_back(s);
  endtask

  // A wait phase: w stalled cycles then completion, or WL stalled cycles ending in an error.
  task automatic add_wait(input logic [3:0] st, input int w, input logic done_on_rdy,
                          output bit ok);
    if (w >= WL) begin
      for (int i = 0; i < WL; i++) add(st, 1'b0, 1'b0, i == WL - 1, 1'b0, 1'b0);
      ok = 1'b0;
    end else begin
      for (int i = 0; i < w; i++) add(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(st, 1'b1, done_on_rdy, 1'b0, 1'b0, 1'b0);
      ok = 1'b1;
    end
  endtask

  task automatic build(input logic [5:0] op, input int fw, input int mw);
    bit ok;
    opcode = op;
    add_wait(4'd0, fw, 1'b0, ok);
    if (!ok) add_wait(4'd0, 0, 1'b0, ok);
    add(4'd1, rr(), 0, 0, 0, 0);
    case (op)
      OP_RTYPE: begin add(4'd6, rr(), 0, 0, 0, 0); add(4'd7, rr(), 1, 0, 0, 1); end
      OP_LW: begin
        add(4'd2, rr(), 0, 0, 0, 0);
        add_wait(4'd3, mw, 1'b0, ok);
        if (ok) add(4'd4, rr(), 1, 0, 0, 1);
      end
      OP_SW: begin add(4'd2, rr(), 0, 0, 0, 0); add_wait(4'd5, mw, 1'b1, ok); end
      OP_BEQ: add(4'd8, rr(), 1, 0, 0, 0);
      OP_J:   add(4'd9, rr(), 1, 0, 0, 0);
`ifdef MULTICYCLE_ADDI_EN
      OP_ADDI: begin add(4'd10, rr(), 0, 0, 0, 0); add(4'd11, rr(), 1, 0, 0, 1); end
`endif
      default: add(4'd12, rr(), 0, 0, 1, 0);
    endcase
  endtask

  task automatic run_steps(input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      @(negedge clk);
      mem_ready = s.rdy;
      #1;
      checks++;
      if (state !== s.st) begin
        errors++; $display("FAIL state: got %0d expected %0d", state, s.st);
      end
      checks++;
      if ({instr_done, mem_err, illegal_op, reg_write} !== {s.done, s.err, s.ill, s.regw}) begin
        errors++;
        $display("FAIL flags(done,err,ill,regw) st=%0d: got %b expected %b", s.st,
                 {instr_done, mem_err, illegal_op, reg_write}, {s.done, s.err, s.ill, s.regw});
      end
      checks++;
      case (s.st)
        4'd0: if ({mem_read, ir_write, pc_write} !== {1'b1, s.rdy, s.rdy}) begin
          errors++; $display("FAIL fetch strobes: got %b expected %b",
                             {mem_read, ir_write, pc_write}, {1'b1, s.rdy, s.rdy}); end
        4'd3: if ({mem_read, i_or_d} !== 2'b11) begin
          errors++; $display("FAIL memrd strobes: got %b expected 11", {mem_read, i_or_d}); end
        4'd4: if (mem_to_reg !== 1'b1) begin
          errors++; $display("FAIL memwb mem_to_reg: got %b expected 1", mem_to_reg); end
        4'd5: if ({mem_write, i_or_d} !== {!s.err, 1'b1}) begin
          errors++; $display("FAIL memwr strobes: got %b expected %b",
                             {mem_write, i_or_d}, {!s.err, 1'b1}); end
        4'd7: if (reg_dst !== 1'b1) begin
          errors++; $display("FAIL aluwb reg_dst: got %b expected 1", reg_dst); end
        4'd8: if ({pc_write_cond, alu_op} !== 3'b101) begin
          errors++; $display("FAIL branch: got %b expected 101", {pc_write_cond, alu_op}); end
        4'd9: if ({pc_write, pc_source} !== 3'b110) begin
          errors++; $display("FAIL jump: got %b expected 110", {pc_write, pc_source}); end
        4'd11: if (reg_dst !== 1'b0) begin
          errors++; $display("FAIL addiwb reg_dst: got %b expected 0", reg_dst); end
        default: if (mem_write !== 1'b0) begin
          errors++; $display("FAIL stray mem_write st=%0d: got %b expected 0", s.st, mem_write); end
      endcase
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; opcode = OP_RTYPE;
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (all_outs !== '0) begin
        errors++; $display("FAIL reset outputs: got %h expected 0", all_outs);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({state, ir_write, pc_write} !== {4'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL post-reset fetch: got %b expected 000011", {state, ir_write, pc_write});
    end
    build(OP_RTYPE, 0, 0);
    void'(q.pop_front());
    run_steps(q.size());
  endtask

  task automatic test_rtype();     build(OP_RTYPE, 0, 0); run_steps(q.size()); endtask
  task automatic test_lw_wait();   build(OP_LW, 0, 3);    run_steps(q.size()); endtask
  task automatic test_sw_timeout(); build(OP_SW, 0, WL + 3); run_steps(q.size()); endtask
  task automatic test_fetch_timeout(); build(OP_BEQ, WL, 0); run_steps(q.size()); endtask

  task automatic test_illegal();
    build(6'h3F, 0, 0); run_steps(q.size());
    build(OP_ADDI, 0, 0); run_steps(q.size());
  endtask

  task automatic test_back_to_back();
    build(OP_BEQ, 0, 0); run_steps(q.size());
    build(OP_J, 0, 0);   run_steps(q.size());
    build(OP_SW, 1, 0);  run_steps(q.size());
  endtask

  task automatic test_reset_mid();
    build(OP_LW, 0, 3);
    run_steps(4);
    q.delete();
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin
      errors++; $display("FAIL mid-reset outputs: got %h expected 0", all_outs);
    end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1;
    #1;
    checks++;
    if ({state, ir_write, reg_write} !== {4'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid-reset recovery: got %b expected 000010", {state, ir_write, reg_write});
    end
    build(OP_J, 0, 0);
    void'(q.pop_front());
    run_steps(q.size());
  endtask

  task automatic test_random();
    logic [5:0] ops [6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    logic [5:0] op;
    int fw, mw;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 6) == 0) op = 6'($urandom_range(0, 63));
      else op = ops[$urandom_range(0, 5)];
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WL + 1)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WL + 1)) : 0;
      build(op, fw, mw);
      run_steps(q.size());
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_timeout();
    test_fetch_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
